// File: rtl/sprite_layer_mux.sv
// Per-pixel sprite compositor with player/obstacle overlap tracking and per-frame collision events.
// Latency 1 cycle for rgb_out; events issued the cycle after the closing frame_start; no backpressure.
// Optional macro SPRITE_MUX_COOLDOWN_EN adds a COOLDOWN state that suppresses events for COOLDOWN_FRAMES frames.
module sprite_layer_mux #(
    parameter int         NUM_LAYERS      = 4,
    parameter logic [7:0] MASK_VALUE      = 8'h62,
    parameter int         COOLDOWN_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          frame_start,
    input  logic                          draw_enable,
    input  logic [NUM_LAYERS*8-1:0]       layer_color,
    input  logic [7:0]                    bg_color,
    output logic [7:0]                    rgb_out,
    output logic [NUM_LAYERS-2:0]         hit_flags,
    output logic                          collision_pulse,
    output logic [$clog2(NUM_LAYERS)-1:0] collision_layer
);

    localparam int OBS = NUM_LAYERS - 1;
    localparam int LW  = $clog2(NUM_LAYERS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REPORT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            rgb_q, rgb_d;
    logic [OBS-1:0]        acc_q, acc_d;
    logic [OBS-1:0]        hit_q, hit_d;
    logic [LW-1:0]         layer_q, layer_d;
    logic [NUM_LAYERS-1:0] opaque;
    logic [OBS-1:0]        ov;
    logic [LW-1:0]         first_idx;

`ifdef SPRITE_MUX_COOLDOWN_EN
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Lowest-index opaque layer wins; the background shows through only when all are transparent.
    always_comb begin
        opaque = '0;
        rgb_d  = bg_color;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            opaque[k] = (layer_color[k*8 +: 8] != MASK_VALUE);
        end
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                rgb_d = layer_color[k*8 +: 8];
            end
        end
        if (!draw_enable) begin
            rgb_d = 8'h00;
        end
    end

    always_comb begin
        ov = '0;
        for (int k = 1; k < NUM_LAYERS; k++) begin
            ov[k-1] = draw_enable & opaque[0] & opaque[k];
        end
    end

    // The boundary cycle's own overlap belongs to the new frame, never to the one being closed.
    always_comb begin
        acc_d = acc_q | ov;
        hit_d = hit_q;
        if (frame_start) begin
            acc_d = ov;
            hit_d = acc_q;
        end
    end

    always_comb begin
        first_idx = '0;
        for (int k = OBS - 1; k >= 0; k--) begin
            if (acc_q[k]) begin
                first_idx = LW'(k + 1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            rgb_q   <= 8'h00;
            acc_q   <= '0;
            hit_q   <= '0;
            layer_q <= '0;
`ifdef SPRITE_MUX_COOLDOWN_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            acc_q   <= acc_d;
            hit_q   <= hit_d;
            layer_q <= layer_d;
`ifdef SPRITE_MUX_COOLDOWN_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
`ifdef SPRITE_MUX_COOLDOWN_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_start && (acc_q != '0)) begin
                    state_d = REPORT;
                    layer_d = first_idx;
                end
            end
            REPORT: begin
`ifdef SPRITE_MUX_COOLDOWN_EN
                if (COOLDOWN_FRAMES > 0) begin
                    state_d = COOLDOWN;
                    cnt_d   = CNT_W'(COOLDOWN_FRAMES);
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            COOLDOWN: begin
`ifdef SPRITE_MUX_COOLDOWN_EN
                if (frame_start) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        collision_pulse = (state_q == REPORT);
        rgb_out         = rgb_q;
        hit_flags       = hit_q;
        collision_layer = layer_q;
    end

endmodule
